// File: rtl/fp_cmp_arbiter.sv
// rtl/fp_cmp_arbiter.sv - round-robin shared IEEE-754 single comparator, 2-stage pipeline
// Optional NaN/unordered detection enabled by defining FP_CMP_NAN_EN
module fp_comparator (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        eq_o,
    output logic        lt_o,
    output logic        gt_o
);
    logic        both_zero;
    logic [31:0] key_a;
    logic [31:0] key_b;

    // Remap sign-magnitude to an unsigned total order; +0 and -0 are then equated explicitly
    assign key_a     = a_i[31] ? ~a_i : {1'b1, a_i[30:0]};
    assign key_b     = b_i[31] ? ~b_i : {1'b1, b_i[30:0]};
    assign both_zero = (a_i[30:0] == 31'd0) && (b_i[30:0] == 31'd0);
    assign eq_o      = (a_i == b_i) || both_zero;
    assign lt_o      = (key_a < key_b) && !both_zero;
    assign gt_o      = !eq_o && !lt_o;
endmodule

module fp_cmp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] op_a,
    input  logic [32*NREQ-1:0] op_b,
    input  logic [3*NREQ-1:0]  cond,
    output logic [NREQ-1:0]    gnt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic               res_flag,
    output logic               res_unord,
    output logic               busy
);
    logic [NREQ-1:0] gnt_q, gnt_d, cand;
    logic [IDW-1:0]  rr_q, rr_d, grant_idx;
    logic [IDW:0]    sum;
    logic            found, grant_any, stall;
    logic            s1_vld_q;
    logic [31:0]     s1_a_q, s1_b_q;
    logic [2:0]      s1_cond_q;
    logic [IDW-1:0]  s1_id_q;
    logic            res_valid_q, res_flag_q, flag_d;
    logic [IDW-1:0]  res_id_q;
    logic            cmp_eq, cmp_lt, cmp_gt;

    assign stall = res_valid_q && !res_ready;
    assign cand  = req & ~gnt_q;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            if (!found && cand[sum[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = sum[IDW-1:0];
            end
        end
        // Stage 1 must be empty or draining into stage 2 this edge
        grant_any = found && (!s1_vld_q || !stall);
        gnt_d     = '0;
        if (grant_any) gnt_d[grant_idx] = 1'b1;
        rr_d      = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end

    fp_comparator u_cmp (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .eq_o(cmp_eq),
        .lt_o(cmp_lt),
        .gt_o(cmp_gt)
    );

`ifdef FP_CMP_NAN_EN
    logic unord_d, res_unord_q;
    assign unord_d = ((s1_a_q[30:23] == 8'hFF) && (s1_a_q[22:0] != 23'd0)) ||
                     ((s1_b_q[30:23] == 8'hFF) && (s1_b_q[22:0] != 23'd0));
`endif

    always_comb begin
        flag_d = 1'b0;
        case (s1_cond_q)
            3'b000:  flag_d = cmp_eq;
            3'b001:  flag_d = cmp_lt;
            3'b010:  flag_d = cmp_lt | cmp_eq;
            3'b011:  flag_d = cmp_gt;
            3'b100:  flag_d = cmp_gt | cmp_eq;
            3'b101:  flag_d = ~cmp_eq;
            default: flag_d = 1'b0;
        endcase
`ifdef FP_CMP_NAN_EN
        if (unord_d) flag_d = (s1_cond_q == 3'b101);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            rr_q        <= '0;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cond_q   <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_flag_q  <= 1'b0;
`ifdef FP_CMP_NAN_EN
            res_unord_q <= 1'b0;
`endif
        end else begin
            gnt_q <= gnt_d;
            if (!stall) begin
                res_valid_q <= s1_vld_q;
                if (s1_vld_q) begin
                    res_id_q   <= s1_id_q;
                    res_flag_q <= flag_d;
`ifdef FP_CMP_NAN_EN
                    res_unord_q <= unord_d;
`endif
                end
            end
            if (grant_any) begin
                s1_vld_q  <= 1'b1;
                s1_a_q    <= op_a[32*grant_idx +: 32];
                s1_b_q    <= op_b[32*grant_idx +: 32];
                s1_cond_q <= cond[3*grant_idx +: 3];
                s1_id_q   <= grant_idx;
                rr_q      <= rr_d;
            end else if (!stall) begin
                s1_vld_q <= 1'b0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_flag  = res_flag_q;
    assign busy      = s1_vld_q | res_valid_q;
`ifdef FP_CMP_NAN_EN
    assign res_unord = res_unord_q;
`else
    assign res_unord = 1'b0;
`endif
endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// tb/tb_fp_cmp_arbiter.sv - directed self-checking bench for fp_cmp_arbiter
module tb_fp_cmp_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] op_a, op_b;
    logic [3*NREQ-1:0]  cond;
    logic [NREQ-1:0]    gnt;
    logic               res_valid, res_ready, res_flag, res_unord, busy;
    logic [IDW-1:0]     res_id;

    int checks   = 0;
    int failures = 0;

    fp_cmp_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .cond(cond),
        .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_flag(res_flag), .res_unord(res_unord), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        op_a[32*i +: 32] = a;
        op_b[32*i +: 32] = b;
        cond[3*i +: 3]   = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; res_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
    endtask

    // One isolated compare through requester 0; returns the observed result
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                           output logic vld, output logic flg, output logic uno);
        set_op(0, a, b, c);
        req = 4'b0001;
        step();
        req = '0;
        step();
        vld = res_valid; flg = res_flag; uno = res_unord;
        step();
    endtask

    task automatic test_reset();
        op_a = '0; op_b = '0; cond = '0;
        do_reset();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++; if (res_id !== 2'd0 || res_flag !== 1'b0 || res_unord !== 1'b0) begin
            failures++; $display("FAIL reset_res got id=%0d flag=%b unord=%b exp 0 0 0", res_id, res_flag, res_unord); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        set_op(0, 32'h3F800000, 32'h40000000, 3'b001);
        req = 4'b0001;
        step();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", res_valid); end
        req = '0;
        step();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_flag !== 1'b1) begin
            failures++; $display("FAIL single_res got v=%b id=%0d f=%b exp v=1 id=0 f=1", res_valid, res_id, res_flag); end
        step();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL single_drain got v=%b busy=%b exp 0 0", res_valid, busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_flag;
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000, 3'b001);
        set_op(1, 32'h3F800000, 32'h40000000, 3'b011);
        set_op(2, 32'h3F800000, 32'h40000000, 3'b010);
        set_op(3, 32'h3F800000, 32'h40000000, 3'b000);
        exp_flag = 4'b0101;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) begin
                checks++; if (gnt !== 4'(1 << k)) begin failures++; $display("FAIL b2b_gnt%0d got=%b exp=%b", k, gnt, 4'(1 << k)); end
                req[k] = 1'b0;
            end
            if (k >= 1) begin
                checks++; if (res_valid !== 1'b1 || res_id !== 2'(k-1) || res_flag !== exp_flag[k-1]) begin
                    failures++; $display("FAIL b2b_res%0d got v=%b id=%0d f=%b exp v=1 id=%0d f=%b",
                                         k, res_valid, res_id, res_flag, k-1, exp_flag[k-1]); end
            end
        end
        step();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", res_valid); end
    endtask

    task automatic test_rotate();
        logic [3:0] prev;
        do_reset();
        prev = '0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (gnt !== 4'(1 << (k % 4)) || gnt === prev) begin
                failures++; $display("FAIL rotate%0d got=%b exp=%b prev=%b", k, gnt, 4'(1 << (k % 4)), prev); end
            prev = gnt;
        end
        req = '0;
        step(); step(); step();
    endtask

    task automatic test_stall();
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000, 3'b001);
        set_op(1, 32'h3F800000, 32'h40000000, 3'b011);
        set_op(2, 32'h40000000, 32'h3F800000, 3'b100);
        req = 4'b0001;
        step();
        req = 4'b0110; res_ready = 1'b0;
        step();
        checks++; if (gnt !== 4'b0010 || res_valid !== 1'b1 || res_id !== 2'd0) begin
            failures++; $display("FAIL stall_grant1 got gnt=%b v=%b id=%0d exp 0010 1 0", gnt, res_valid, res_id); end
        req = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_id !== 2'd0 || res_flag !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got gnt=%b v=%b id=%0d f=%b exp 0000 1 0 1",
                                     k, gnt, res_valid, res_id, res_flag); end
        end
        res_ready = 1'b1;
        step();
        checks++; if (gnt !== 4'b0100 || res_valid !== 1'b1 || res_id !== 2'd1 || res_flag !== 1'b0) begin
            failures++; $display("FAIL stall_res1 got gnt=%b v=%b id=%0d f=%b exp 0100 1 1 0", gnt, res_valid, res_id, res_flag); end
        req = '0;
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_flag !== 1'b1) begin
            failures++; $display("FAIL stall_res2 got v=%b id=%0d f=%b exp 1 2 1", res_valid, res_id, res_flag); end
        step();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL stall_end got=%b exp=0", res_valid); end
    endtask

    task automatic test_cond();
        logic v, f, u;
        logic [31:0] va [6] = '{32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'h00000000, 32'hC0000000};
        logic [31:0] vb [6] = '{32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hC0000000, 32'h80000000, 32'hBF800000};
        logic [2:0]  vc [6] = '{3'b100, 3'b001, 3'b101, 3'b111, 3'b000, 3'b010};
        logic        ve [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            run_one(va[k], vb[k], vc[k], v, f, u);
            checks++; if (v !== 1'b1 || f !== ve[k]) begin
                failures++; $display("FAIL cond%0d got v=%b f=%b exp v=1 f=%b", k, v, f, ve[k]); end
        end
    endtask

    task automatic test_reset_midop();
        logic v, f, u;
        set_op(0, 32'h3F800000, 32'h40000000, 3'b001);
        set_op(1, 32'h3F800000, 32'h40000000, 3'b001);
        req = 4'b0001;
        step();
        req = 4'b0010; res_ready = 1'b0;
        step();
        checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL midop_full got v=%b busy=%b exp 1 1", res_valid, busy); end
        req = '0; rst_n = 1'b0;
        step();
        checks++; if (gnt !== 4'b0000 || res_valid !== 1'b0 || res_id !== 2'd0 || res_flag !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midop_reset got gnt=%b v=%b id=%0d f=%b busy=%b exp all 0",
                                 gnt, res_valid, res_id, res_flag, busy); end
        rst_n = 1'b1; res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midop_stale%0d got=%b exp=0", k, res_valid); end
        end
        req = 4'b1111;
        step();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midop_ptr got=%b exp=0001", gnt); end
        req = '0;
        step(); step();
        run_one(32'h7FC00000, 32'h3F800000, 3'b000, v, f, u);
`ifdef FP_CMP_NAN_EN
        checks++; if (v !== 1'b1 || f !== 1'b0 || u !== 1'b1) begin
            failures++; $display("FAIL nan_eq got v=%b f=%b u=%b exp 1 0 1", v, f, u); end
        run_one(32'h7FC00000, 32'h3F800000, 3'b101, v, f, u);
        checks++; if (v !== 1'b1 || f !== 1'b1 || u !== 1'b1) begin
            failures++; $display("FAIL nan_ne got v=%b f=%b u=%b exp 1 1 1", v, f, u); end
`else
        checks++; if (v !== 1'b1 || u !== 1'b0) begin
            failures++; $display("FAIL nan_off got v=%b u=%b exp 1 0", v, u); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rotate();
        test_stall();
        test_cond();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
